// File: rtl/systolic_sequencer_if.sv
// Bundles the load stream, array-side feed/readback signals and result stream of
// systolic_sequencer. The sequencer uses the slave view; its environment uses master.
interface systolic_sequencer_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
);
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][W-1:0]   in_x;
  logic [N-1:0][W-1:0]   in_w;
  logic [N-1:0][W-1:0]   x_out;
  logic [N-1:0][W-1:0]   w_out;
  logic                  start_out;
  logic                  array_stall;
  logic [RowW-1:0]       y_index;
  logic [N-1:0][W-1:0]   y_in;
  logic                  res_valid;
  logic                  res_ready;
  logic [N-1:0][W-1:0]   res_data;
  logic [RowW-1:0]       res_row;
  logic                  busy;
  logic                  done;

  modport slave (
    input  clear, in_valid, in_x, in_w, array_stall, y_in, res_ready,
    output in_ready, x_out, w_out, start_out, y_index, res_valid, res_data, res_row, busy, done
  );

  modport master (
    output clear, in_valid, in_x, in_w, array_stall, y_in, res_ready,
    input  in_ready, x_out, w_out, start_out, y_index, res_valid, res_data, res_row, busy, done
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Tile controller for a systolic array: buffers an NxN tile, feeds it with diagonal skew,
// waits for the array to settle, then reads result rows back out over valid/ready.
module systolic_sequencer #(
  parameter int unsigned N            = 4,
  parameter int unsigned W            = 16,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  systolic_sequencer_if.slave seq_if
);

  localparam int unsigned CntW = $clog2(2 * N);
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DrnW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [CntW-1:0] LastStep  = CntW'(2 * N - 2);
  localparam logic [RowW-1:0] LastBeat  = RowW'(N - 1);
  localparam logic [RowW-1:0] LastRow   = RowW'(N - 1);
  localparam logic [DrnW-1:0] LastDrain = DrnW'(DRAIN_CYCLES - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StFeed  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StRead  = 3'd4;

  typedef logic [N-1:0][W-1:0]         vec_t;
  typedef logic [N-1:0][N-1:0][W-1:0]  tile_t;

  logic [2:0]       state_q, state_d;
  logic [RowW-1:0]  ld_cnt_q, ld_cnt_d;
  tile_t            xbuf_q, xbuf_d;
  tile_t            wbuf_q, wbuf_d;
  logic [CntW-1:0]  t_q, t_d;
  logic [DrnW-1:0]  drain_q, drain_d;
  logic [RowW-1:0]  r_q, r_d;
  vec_t             x_out_q, x_out_d;
  vec_t             w_out_q, w_out_d;
  vec_t             res_data_q, res_data_d;
  logic             start_q, start_d;
  logic             res_valid_q, res_valid_d;
  logic             done_q, done_d;

  // Diagonal skew: lane i at step t carries element i of vector (t - i), zero outside the tile.
  function automatic vec_t skew(input tile_t buf_v, input logic [CntW-1:0] t);
    vec_t v;
    v = '0;
    for (int k = 0; k < int'(N); k++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (k + i == int'(t)) begin
          v[i] = buf_v[k][i];
        end
      end
    end
    return v;
  endfunction

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    xbuf_d      = xbuf_q;
    wbuf_d      = wbuf_q;
    t_d         = t_q;
    drain_d     = drain_q;
    r_d         = r_q;
    x_out_d     = x_out_q;
    w_out_d     = w_out_q;
    start_d     = start_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    done_d      = 1'b0;

    if (seq_if.clear) begin
      state_d     = StIdle;
      ld_cnt_d    = '0;
      xbuf_d      = '0;
      wbuf_d      = '0;
      t_d         = '0;
      drain_d     = '0;
      r_d         = '0;
      x_out_d     = '0;
      w_out_d     = '0;
      start_d     = 1'b0;
      res_data_d  = '0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle, StLoad: begin
          if (seq_if.in_valid) begin
            xbuf_d[ld_cnt_q] = seq_if.in_x;
            wbuf_d[ld_cnt_q] = seq_if.in_w;
            if (ld_cnt_q == LastBeat) begin
              // Step 0 is presented in the first FEED cycle, so it is registered on this edge.
              ld_cnt_d = '0;
              state_d  = StFeed;
              t_d      = '0;
              x_out_d  = skew(xbuf_d, '0);
              w_out_d  = skew(wbuf_d, '0);
              start_d  = 1'b1;
            end else begin
              ld_cnt_d = ld_cnt_q + RowW'(1);
              state_d  = StLoad;
            end
          end
        end

        StFeed: begin
          if (!seq_if.array_stall) begin
            if (t_q == LastStep) begin
              state_d = StDrain;
              t_d     = '0;
              drain_d = '0;
              x_out_d = '0;
              w_out_d = '0;
              start_d = 1'b0;
            end else begin
              t_d     = t_q + CntW'(1);
              x_out_d = skew(xbuf_q, t_q + CntW'(1));
              w_out_d = skew(wbuf_q, t_q + CntW'(1));
            end
          end
        end

        StDrain: begin
          if (drain_q == LastDrain) begin
            state_d = StRead;
            drain_d = '0;
            r_d     = '0;
          end else begin
            drain_d = drain_q + DrnW'(1);
          end
        end

        StRead: begin
          // Alternate between letting y_index settle (capture) and offering the row.
          if (!res_valid_q) begin
            res_data_d  = seq_if.y_in;
            res_valid_d = 1'b1;
          end else if (seq_if.res_ready) begin
            res_valid_d = 1'b0;
            if (r_q == LastRow) begin
              r_d     = '0;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              r_d = r_q + RowW'(1);
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      ld_cnt_q    <= '0;
      xbuf_q      <= '0;
      wbuf_q      <= '0;
      t_q         <= '0;
      drain_q     <= '0;
      r_q         <= '0;
      x_out_q     <= '0;
      w_out_q     <= '0;
      start_q     <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      xbuf_q      <= xbuf_d;
      wbuf_q      <= wbuf_d;
      t_q         <= t_d;
      drain_q     <= drain_d;
      r_q         <= r_d;
      x_out_q     <= x_out_d;
      w_out_q     <= w_out_d;
      start_q     <= start_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  // r_q is held at zero outside READ, so it doubles as the idle y_index value.
  assign seq_if.in_ready  = (state_q == StIdle) || (state_q == StLoad);
  assign seq_if.x_out     = x_out_q;
  assign seq_if.w_out     = w_out_q;
  assign seq_if.start_out = start_q;
  assign seq_if.y_index   = r_q;
  assign seq_if.res_valid = res_valid_q;
  assign seq_if.res_data  = res_data_q;
  assign seq_if.res_row   = r_q;
  assign seq_if.busy      = (state_q != StIdle);
  assign seq_if.done      = done_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: a behavioural array returns golden product rows,
// and expected rows are queued at load time and popped as the DUT hands them out.
module tb_systolic_sequencer;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int DRAIN = 8;

  typedef logic [N-1:0][W-1:0]        vec_t;
  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;

  logic clk;
  logic n_rst;
  mat_t y_tab;
  vec_t sb[$];
  int   checks;
  int   errors;

  systolic_sequencer_if #(.N(N), .W(W)) sif ();

  systolic_sequencer #(.N(N), .W(W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .seq_if (sif)
  );

  // Stand-in for the array: y_out is the golden result row selected by y_index.
  assign sif.y_in = y_tab[sif.y_index];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t exp_skew(input mat_t m, input int t);
    vec_t v;
    v = '0;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++)
        if (k + i == t) v[i] = m[k][i];
    return v;
  endfunction

  function automatic mat_t golden(input mat_t xs, input mat_t ws);
    mat_t y;
    int unsigned acc;
    y = '0;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc = acc + 32'(xs[k][r]) * 32'(ws[k][j]);
        y[r][j] = 16'(acc);
      end
    return y;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) m[k][i] = 16'($urandom_range(0, 255));
    return m;
  endfunction

  task automatic run_tile(input mat_t xs, input mat_t ws, input int stall_at, input int stall_len,
                          input int hold_row, input bit hold_valid, input int rst_row,
                          input bit chk_t3);
    mat_t g;
    int   t;
    int   cyc;
    int   stalled;
    int   w;
    bit   stall;
    vec_t exp;
    g     = golden(xs, ws);
    y_tab = g;
    for (int r = 0; r < N; r++) sb.push_back(g[r]);

    for (int k = 0; k < N; k++) begin
      sif.in_valid = 1'b1;
      sif.in_x     = xs[k];
      sif.in_w     = ws[k];
      chk("load_in_ready", 64'(sif.in_ready), 64'd1);
      tick();
    end
    sif.in_valid = hold_valid;
    sif.in_x     = {N{16'hBEEF}};
    sif.in_w     = {N{16'hDEAD}};

    t       = 0;
    cyc     = 0;
    stalled = 0;
    while (t < 2 * N - 1 && cyc < 40) begin
      stall           = (t == stall_at) && (stalled < stall_len);
      sif.array_stall = stall;
      chk("feed_start", 64'(sif.start_out), 64'd1);
      chk("feed_x", 64'(sif.x_out), 64'(exp_skew(xs, t)));
      chk("feed_w", 64'(sif.w_out), 64'(exp_skew(ws, t)));
      chk("feed_in_ready", 64'(sif.in_ready), 64'd0);
      if (chk_t3 && t == 3) chk("t3_x", 64'(sif.x_out), 64'h0000_0001_0002_0003);
      tick();
      cyc++;
      if (stall) stalled++;
      else t++;
    end
    sif.array_stall = 1'b0;
    chk("feed_len", 64'(cyc), 64'(2 * N - 1 + stall_len));
    chk("drain_start_low", 64'(sif.start_out), 64'd0);
    chk("drain_x_zero", 64'(sif.x_out), 64'd0);

    cyc = 0;
    while (!sif.res_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("first_row_latency", 64'(cyc), 64'(DRAIN + 1));

    sif.res_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      w = 0;
      while (!sif.res_valid && w < 20) begin
        tick();
        w++;
      end
      if (r > 0) chk("row_rate", 64'(w), 64'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      chk("res_valid", 64'(sif.res_valid), 64'd1);
      chk("res_row", 64'(sif.res_row), 64'(r));
      chk("res_data", 64'(sif.res_data), 64'(exp));
      chk("read_in_ready", 64'(sif.in_ready), 64'd0);
      if (r == rst_row) begin
        n_rst = 1'b0;
        #1;
        chk("rst_res_valid", 64'(sif.res_valid), 64'd0);
        chk("rst_res_data", 64'(sif.res_data), 64'd0);
        chk("rst_busy", 64'(sif.busy), 64'd0);
        chk("rst_y_index", 64'(sif.y_index), 64'd0);
        chk("rst_in_ready", 64'(sif.in_ready), 64'd1);
        sb.delete();
        sif.in_valid  = 1'b0;
        sif.res_ready = 1'b0;
        #2;
        n_rst = 1'b1;
        tick();
        return;
      end
      if (r == hold_row) begin
        sif.res_ready = 1'b0;
        repeat (5) begin
          tick();
          chk("hold_valid", 64'(sif.res_valid), 64'd1);
          chk("hold_row", 64'(sif.res_row), 64'(r));
          chk("hold_data", 64'(sif.res_data), 64'(exp));
        end
        sif.res_ready = 1'b1;
      end
      if (r == N - 1) sif.in_valid = 1'b0;
      tick();
    end
    chk("done_pulse", 64'(sif.done), 64'd1);
    chk("done_busy", 64'(sif.busy), 64'd0);
    tick();
    chk("done_clear", 64'(sif.done), 64'd0);
    chk("idle_ready", 64'(sif.in_ready), 64'd1);
  endtask

  initial begin
    mat_t xs;
    mat_t ws;
    checks          = 0;
    errors          = 0;
    y_tab           = '0;
    n_rst           = 1'b0;
    sif.clear       = 1'b0;
    sif.in_valid    = 1'b0;
    sif.in_x        = '0;
    sif.in_w        = '0;
    sif.array_stall = 1'b0;
    sif.res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;

    chk("reset_in_ready", 64'(sif.in_ready), 64'd1);
    chk("reset_busy", 64'(sif.busy), 64'd0);
    chk("reset_start", 64'(sif.start_out), 64'd0);
    chk("reset_x", 64'(sif.x_out), 64'd0);
    chk("reset_res_valid", 64'(sif.res_valid), 64'd0);
    chk("reset_done", 64'(sif.done), 64'd0);
    tick();

    // Every element of beat k is k.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        xs[k][i] = 16'(k);
        ws[k][i] = 16'(k);
      end
    run_tile(xs, ws, -1, 0, -1, 1'b0, -1, 1'b1);

    xs = '0;
    ws = '0;
    for (int k = 0; k < N; k++) begin
      xs[k][k] = 16'd1;
      ws[k][k] = 16'd2;
    end
    run_tile(xs, ws, -1, 0, -1, 1'b0, -1, 1'b0);

    run_tile(rand_mat(), rand_mat(), 2, 3, -1, 1'b0, -1, 1'b0);
    run_tile(rand_mat(), rand_mat(), -1, 0, 1, 1'b0, -1, 1'b0);

    // Partial load, then clear coinciding with a third beat.
    sif.in_valid = 1'b1;
    sif.in_x     = {N{16'h1111}};
    sif.in_w     = {N{16'h2222}};
    tick();
    tick();
    sif.clear = 1'b1;
    sif.in_x  = {N{16'h3333}};
    tick();
    sif.clear    = 1'b0;
    sif.in_valid = 1'b0;
    chk("clear_busy", 64'(sif.busy), 64'd0);
    chk("clear_in_ready", 64'(sif.in_ready), 64'd1);
    run_tile(rand_mat(), rand_mat(), -1, 0, -1, 1'b0, -1, 1'b0);

    run_tile(rand_mat(), rand_mat(), -1, 0, -1, 1'b1, -1, 1'b0);
    run_tile(rand_mat(), rand_mat(), -1, 0, -1, 1'b1, 2, 1'b0);
    chk("post_rst_busy", 64'(sif.busy), 64'd0);
    run_tile(rand_mat(), rand_mat(), 0, 1, 3, 1'b0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
